// File: rtl/traffic_light_xing.sv
// rtl/traffic_light_xing.sv - two-road traffic light controller with pedestrian shortening
// Optional night flash mode: define TL_NIGHT_FLASH_EN.
module traffic_light_xing #(
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 60,
  parameter int YELLOW_T = 5,
  parameter int ALLRED_T = 2,
  parameter int PED_T    = 10,
  parameter int FLASH_T  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ped_req,
  input  logic             night,
  output logic             a_red,
  output logic             a_yellow,
  output logic             a_green,
  output logic             b_red,
  output logic             b_yellow,
  output logic             b_green,
  output logic [CNT_W-1:0] clock,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    A_CLR = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    B_CLR = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_GREEN  = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] L_PED    = CNT_W'(PED_T);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  logic             w_ped_cut;

  // Phase ends on the edge where the counter sits at 1.
  assign w_last    = (r_cnt == L_ONE);
  // A pedestrian only ever shortens a green, never lengthens it.
  assign w_ped_cut = ped_req && (r_cnt > L_PED);

`ifdef TL_NIGHT_FLASH_EN
  localparam logic [CNT_W-1:0] L_FLASH = CNT_W'(FLASH_T);
  logic r_flash_bit;
`else
  logic w_night_unused;
  assign w_night_unused = night;
`endif

  // Phase sequencer: state, countdown and (optionally) flash toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= B_CLR;
      r_cnt       <= L_ALLRED;
`ifdef TL_NIGHT_FLASH_EN
      r_flash_bit <= 1'b0;
`endif
    end else begin
      case (r_state)
        A_GRN: begin
          if (w_last) begin
            r_state <= A_YEL;
            r_cnt   <= L_YELLOW;
          end else if (w_ped_cut) begin
            r_cnt <= L_PED;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        A_YEL: begin
          if (w_last) begin
            r_state <= A_CLR;
            r_cnt   <= L_ALLRED;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        A_CLR: begin
          if (w_last) begin
`ifdef TL_NIGHT_FLASH_EN
            if (night) begin
              r_state     <= FLASH;
              r_cnt       <= L_FLASH;
              r_flash_bit <= 1'b1;
            end else begin
              r_state <= B_GRN;
              r_cnt   <= L_GREEN;
            end
`else
            r_state <= B_GRN;
            r_cnt   <= L_GREEN;
`endif
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        B_GRN: begin
          if (w_last) begin
            r_state <= B_YEL;
            r_cnt   <= L_YELLOW;
          end else if (w_ped_cut) begin
            r_cnt <= L_PED;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        B_YEL: begin
          if (w_last) begin
            r_state <= B_CLR;
            r_cnt   <= L_ALLRED;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        B_CLR: begin
          if (w_last) begin
`ifdef TL_NIGHT_FLASH_EN
            if (night) begin
              r_state     <= FLASH;
              r_cnt       <= L_FLASH;
              r_flash_bit <= 1'b1;
            end else begin
              r_state <= A_GRN;
              r_cnt   <= L_GREEN;
            end
`else
            r_state <= A_GRN;
            r_cnt   <= L_GREEN;
`endif
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
`ifdef TL_NIGHT_FLASH_EN
        FLASH: begin
          if (w_last) begin
            if (night) begin
              r_cnt       <= L_FLASH;
              r_flash_bit <= ~r_flash_bit;
            end else begin
              // Leave through all-red so road A never starts straight from flashing.
              r_state <= B_CLR;
              r_cnt   <= L_ALLRED;
            end
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
`endif
        default: begin
          r_state <= B_CLR;
          r_cnt   <= L_ALLRED;
        end
      endcase
    end
  end

  // Lamps decode directly from the state register so reset shows at once.
  always_comb begin
    a_red    = 1'b1;
    a_yellow = 1'b0;
    a_green  = 1'b0;
    b_red    = 1'b1;
    b_yellow = 1'b0;
    b_green  = 1'b0;
    case (r_state)
      A_GRN: begin
        a_red   = 1'b0;
        a_green = 1'b1;
      end
      A_YEL: begin
        a_red    = 1'b0;
        a_yellow = 1'b1;
      end
      B_GRN: begin
        b_red   = 1'b0;
        b_green = 1'b1;
      end
      B_YEL: begin
        b_red    = 1'b0;
        b_yellow = 1'b1;
      end
`ifdef TL_NIGHT_FLASH_EN
      FLASH: begin
        a_red    = 1'b0;
        b_red    = 1'b0;
        a_yellow = r_flash_bit;
        b_yellow = r_flash_bit;
      end
`endif
      default: begin
        a_red = 1'b1;
        b_red = 1'b1;
      end
    endcase
  end

  assign clock = r_cnt;
  assign phase = r_state;

endmodule
